nonce_scheduler: RTL



---
 rtl/bitcoin_pkg.sv | 19 +
 rtl/nonce_scheduler_if.sv | 27 ++
 rtl/nonce_scheduler_prio_enc.sv | 23 ++
 rtl/nonce_scheduler.sv | 139 +++++++++++++
 4 files changed

// File: rtl/bitcoin_pkg.sv
// Shared definitions for the bitcoin hashing array: scheduler state encoding,
// nonce width and the SHA-256 initial hash values used by the cores.
package bitcoin_pkg;

  localparam int unsigned NONCE_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    DISPATCH,
    DRAIN,
    COMPLETE
  } sched_state_t;

  localparam logic [31:0] SHA256_H0 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

endpackage

// File: rtl/nonce_scheduler_if.sv
// Scheduler-to-core bus: dispatch pulses and job bases out, completion/hit reports back.
// Core i occupies bits [32i+31:32i] of both packed nonce vectors.
interface nonce_scheduler_if #(
  parameter int unsigned NUM_CORES = 4
);
  logic [NUM_CORES-1:0]                      core_start;
  logic [bitcoin_pkg::NONCE_W*NUM_CORES-1:0] core_nonce_base;
  logic [NUM_CORES-1:0]                      core_done;
  logic [NUM_CORES-1:0]                      core_hit;
  logic [bitcoin_pkg::NONCE_W*NUM_CORES-1:0] core_hit_nonce;

  modport master (
    output core_start,
    output core_nonce_base,
    input  core_done,
    input  core_hit,
    input  core_hit_nonce
  );

  modport slave (
    input  core_start,
    input  core_nonce_base,
    output core_done,
    output core_hit,
    output core_hit_nonce
  );
endinterface

// File: rtl/nonce_scheduler_prio_enc.sv
// Lowest-index-set-bit encoder: valid when any request is set, idx of the lowest one.
module prio_enc #(
  parameter int unsigned W     = 4,
  parameter int unsigned IDX_W = (W > 1) ? $clog2(W) : 1
) (
  input  logic [W-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    for (int unsigned i = W; i > 0; i--) begin
      if (req[i-1]) begin
        valid = 1'b1;
        idx   = IDX_W'(i - 1);
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Job controller: carves a nonce range into fixed-size jobs, dispatches them to
// idle hash cores, stops on the first hit, drains in-flight cores and reports.
module nonce_scheduler
  import bitcoin_pkg::*;
#(
  parameter int unsigned NUM_CORES      = 4,
  parameter int unsigned NONCES_PER_JOB = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NONCE_W-1:0]  nonce_base,
  input  logic [NONCE_W-1:0]  num_jobs,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [NONCE_W-1:0]  found_nonce,
  output logic [NONCE_W-1:0]  jobs_issued,
  output logic                protocol_err,
  nonce_scheduler_if.master   cores
);

  localparam int unsigned IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  sched_state_t         state, state_next;
  logic [NUM_CORES-1:0] core_busy, core_busy_next, start_mask;
  logic [NONCE_W-1:0]   next_nonce, jobs_left, jobs_left_next;
  logic [NONCE_W-1:0]   base_q        [NUM_CORES];
  logic [NONCE_W-1:0]   hit_nonce_arr [NUM_CORES];
  logic                 idle_valid, hit_valid, dispatch, hit_now;
  logic [IDX_W-1:0]     idle_idx, hit_idx;

  prio_enc #(.W(NUM_CORES), .IDX_W(IDX_W)) u_idle_sel (
    .req   (~core_busy),
    .valid (idle_valid),
    .idx   (idle_idx)
  );

  prio_enc #(.W(NUM_CORES), .IDX_W(IDX_W)) u_hit_sel (
    .req   (cores.core_done & cores.core_hit),
    .valid (hit_valid),
    .idx   (hit_idx)
  );

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      hit_nonce_arr[i] = cores.core_hit_nonce[i*NONCE_W +: NONCE_W];
    end
  end

  // Selection uses the registered busy mask, so a core freed this cycle waits a cycle.
  assign dispatch       = (state == DISPATCH) && (jobs_left != '0) && !found && idle_valid;
  assign start_mask     = dispatch ? (NUM_CORES'(1) << idle_idx) : '0;
  assign hit_now        = (state != IDLE) && hit_valid && !found;
  assign jobs_left_next = jobs_left - NONCE_W'(dispatch);

  assign busy             = (state != IDLE);
  assign done             = (state == COMPLETE);
  assign cores.core_start = start_mask;

  // The dispatched core sees next_nonce in its start cycle; base_q holds it afterwards.
  always_comb begin
    cores.core_nonce_base = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      cores.core_nonce_base[i*NONCE_W +: NONCE_W] = start_mask[i] ? next_nonce : base_q[i];
    end
  end

  always_comb begin
    state_next     = state;
    core_busy_next = core_busy;
    if (state != IDLE) begin
      core_busy_next = (core_busy & ~cores.core_done) | start_mask;
    end
    case (state)
      IDLE: begin
        if (start) begin
          state_next = (num_jobs == '0) ? COMPLETE : DISPATCH;
        end
      end
      DISPATCH: begin
        if ((jobs_left_next == '0) || hit_now) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (core_busy_next == '0) begin
          state_next = COMPLETE;
        end
      end
      COMPLETE: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      core_busy    <= '0;
      next_nonce   <= '0;
      jobs_left    <= '0;
      found        <= 1'b0;
      found_nonce  <= '0;
      jobs_issued  <= '0;
      protocol_err <= 1'b0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        base_q[i] <= '0;
      end
    end else begin
      state     <= state_next;
      core_busy <= core_busy_next;
      if (state == IDLE) begin
        if (start) begin
          next_nonce   <= nonce_base;
          jobs_left    <= num_jobs;
          found        <= 1'b0;
          found_nonce  <= '0;
          jobs_issued  <= '0;
          protocol_err <= 1'b0;
        end
      end else begin
        if (dispatch) begin
          base_q[idle_idx] <= next_nonce;
          next_nonce       <= next_nonce + NONCE_W'(NONCES_PER_JOB);
          jobs_left        <= jobs_left_next;
          jobs_issued      <= jobs_issued + 1'b1;
        end
        if (hit_now) begin
          found       <= 1'b1;
          found_nonce <= hit_nonce_arr[hit_idx];
        end
        if (|(cores.core_done & ~core_busy)) begin
          protocol_err <= 1'b1;
        end
      end
    end
  end

endmodule
